// File: rtl/div_display.sv
// -----------------------------------------------------------------------------
// div_display
// Shows a captured quotient/remainder pair on a 4-digit, active-low,
// time-multiplexed 7-segment display. The scan order is r units, r tens,
// q units, q tens. A tens digit of zero is blanked.
//
// Parameters
//   N           : width of the q and r operands (1..6, so values stay within 0..63)
//   REFRESH_DIV : clock cycles each digit stays lit (2 or more)
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous, active-high reset
//   q, r   : quotient and remainder from the upstream divider
//   load   : single-cycle strobe that captures q and r
//   seg    : active-low segments, bit6..bit0 = g,f,e,d,c,b,a (registered)
//   an     : active-low digit enables, at most one bit low (registered)
//   loaded : high once a value has been captured since reset
// -----------------------------------------------------------------------------
module div_display #(
  parameter int N           = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] q,
  input  logic [N-1:0] r,
  input  logic         load,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         loaded
);

  localparam int             CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [3:0]     AN_OFF    = 4'b1111;

  // Active-low segment pattern for one decimal digit; anything else is dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Tens digit of a 0..63 value (at most 6).
  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  // Units digit of a 0..63 value.
  function automatic logic [3:0] units_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  logic [N-1:0]  r_q;
  logic [N-1:0]  r_r;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          r_loaded;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;

  logic [5:0]    w_val;
  logic [3:0]    w_tens;
  logic [3:0]    w_units;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;

  // Select the digit for the current slot and build the next segment/anode pattern.
  // idx bit1 picks q over r; idx bit0 picks the tens digit over the units digit.
  always_comb begin
    w_val      = r_idx[1] ? 6'(r_q) : 6'(r_r);
    w_tens     = tens_of(w_val);
    w_units    = units_of(w_val);
    w_seg_next = SEG_BLANK;
    w_an_next  = AN_OFF;
    if (!r_loaded) begin
      w_seg_next = SEG_BLANK;
      w_an_next  = AN_OFF;
    end else begin
      w_an_next = ~(4'b0001 << r_idx);
      if (r_idx[0]) begin
        // Leading-zero suppression applies to the tens slots only.
        w_seg_next = (w_tens == 4'd0) ? SEG_BLANK : seg_code(w_tens);
      end else begin
        w_seg_next = seg_code(w_units);
      end
    end
  end

  // Capture registers, refresh counter, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_r      <= '0;
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_loaded <= 1'b0;
      r_seg    <= SEG_BLANK;
      r_an     <= AN_OFF;
    end else begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (load) begin
        r_q      <= q;
        r_r      <= r;
        r_loaded <= 1'b1;
      end
      // Outputs reflect the pre-edge index and value, so a coincident load and
      // advance both show up together on the following cycle.
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
    end
  end

  assign seg    = r_seg;
  assign an     = r_an;
  assign loaded = r_loaded;

endmodule
